fetch_pc_stack: RTL and testbench

- Instruction-fetch stage directly downstream of the control unit.
- Owns the program counter, computes next-PC from the control unit's s_inc/s_pila/push/pop outputs, and drives the program-memory address that returns the next 16-bit opcode.
- Contains the hardware return-address stack (pila) used by push/pop instructions.

---
 rtl/fetch_pc_stack.sv | 148 ++++++++++++++
 tb/tb_fetch_pc_stack.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_stack.sv
// Instruction-fetch PC with hardware return-address stack (pila).
// Latency: pc/sp update one cycle after control inputs are sampled; pushed entry poppable next cycle.
// Backpressure: hold=1 freezes pc, sp and stack; with FETCH_STACK_GUARD_EN an error halts until reset.
//
// Optional feature macro: FETCH_STACK_GUARD_EN
//   defined   : any stack error (overflow, underflow, push+pop together) sets
//               stack_err/halted and freezes pc, sp and the stack until reset.
//   undefined : errors are absorbed and the core keeps running; stack_err and
//               halted are tied low.
//
// Ports:
//   clk, reset (async active-low)
//   hold                 - stall, all state frozen
//   s_inc, s_pila        - next-PC select: sequential / jump, return from stack
//   push, pop            - stack operations
//   jump_addr [PC_W]     - jump target (opcode low bits)
//   pc [PC_W]            - program-memory address
//   sp                   - stack occupancy 0..STACK_DEPTH
//   stack_full, stack_empty, stack_err, halted - status

module fetch_pc_stack #(
    parameter int PC_W        = 10,
    parameter int STACK_DEPTH = 8,
    parameter int RESET_PC    = 0,
    localparam int SP_W       = $clog2(STACK_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              s_inc,
    input  logic              s_pila,
    input  logic              push,
    input  logic              pop,
    input  logic [PC_W-1:0]   jump_addr,
    output logic [PC_W-1:0]   pc,
    output logic [SP_W-1:0]   sp,
    output logic              stack_full,
    output logic              stack_empty,
    output logic              stack_err,
    output logic              halted
);

    localparam int IDX_W = $clog2(STACK_DEPTH);

    localparam logic [PC_W-1:0]  PC_ONE  = 1;
    localparam logic [PC_W-1:0]  PC_RST  = PC_W'(RESET_PC);
    localparam logic [SP_W-1:0]  SP_ONE  = 1;
    localparam logic [SP_W-1:0]  SP_FULL = SP_W'(STACK_DEPTH);
    localparam logic [IDX_W-1:0] IDX_ONE = 1;

    logic [PC_W-1:0]  stack_mem [STACK_DEPTH];

    logic [PC_W-1:0]  pc_inc;
    logic [PC_W-1:0]  seq_pc;
    logic [PC_W-1:0]  rd_dat;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [PC_W-1:0]  nxt_pc;
    logic [SP_W-1:0]  nxt_sp;
    logic             wr_req;
    logic             run;

    assign stack_full  = (sp == SP_FULL);
    assign stack_empty = (sp == '0);

    // Natural PC_W-bit overflow gives the required modulo-2^PC_W wrap,
    // both for the sequential PC and for the pushed return address.
    assign pc_inc = pc + PC_ONE;
    assign seq_pc = s_inc ? pc_inc : jump_addr;

    // Low index bits of sp address the RAM directly: when full, sp's low
    // bits are zero and the top entry (DEPTH-1) is still reached by -1.
    assign wr_idx = sp[IDX_W-1:0];
    assign rd_idx = sp[IDX_W-1:0] - IDX_ONE;
    assign rd_dat = stack_mem[rd_idx];

    assign run = !hold && !halted;

    always_comb begin
        nxt_pc = pc_inc;
        nxt_sp = sp;
        wr_req = 1'b0;
        if (push && pop) begin
            // Illegal combination: stack untouched, just step past it.
            nxt_pc = pc_inc;
        end else if (pop) begin
            if (!stack_empty) begin
                nxt_sp = sp - SP_ONE;
                nxt_pc = s_pila ? rd_dat : seq_pc;
            end
            // Underflow keeps the pc_inc default.
        end else begin
            nxt_pc = seq_pc;
            if (push && !stack_full) begin
                wr_req = 1'b1;
                nxt_sp = sp + SP_ONE;
            end
        end
    end

`ifdef FETCH_STACK_GUARD_EN
    logic err_evt;
    logic err_q;

    assign err_evt = (push && pop)
                   || (pop && !push && stack_empty)
                   || (push && !pop && stack_full);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (run && err_evt) begin
            err_q <= 1'b1;
        end
    end

    assign stack_err = err_q;
    assign halted    = err_q;
`else
    assign stack_err = 1'b0;
    assign halted    = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= PC_RST;
            sp <= '0;
        end else if (run) begin
`ifdef FETCH_STACK_GUARD_EN
            // The erroring instruction does not advance the PC.
            if (!err_evt) begin
                pc <= nxt_pc;
            end
`else
            pc <= nxt_pc;
`endif
            sp <= nxt_sp;
        end
    end

    // Stack RAM is not reset; sp returning to 0 makes old contents invisible.
    always_ff @(posedge clk) begin
        if (run && wr_req) begin
            stack_mem[wr_idx] <= pc_inc;
        end
    end

endmodule

// File: tb/tb_fetch_pc_stack.sv
module tb_fetch_pc_stack;

    localparam int PC_W   = 10;
    localparam int DEPTH  = 8;
    localparam int PC_MOD = 1 << PC_W;
`ifdef FETCH_STACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic            clk;
    logic            reset;
    logic            hold;
    logic            s_inc;
    logic            s_pila;
    logic            push;
    logic            pop;
    logic [PC_W-1:0] jump_addr;
    logic [PC_W-1:0] pc;
    logic [3:0]      sp;
    logic            stack_full;
    logic            stack_empty;
    logic            stack_err;
    logic            halted;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: PC as an integer, return stack as a queue.
    int m_pc;
    int m_q[$];
    bit m_halt;

    fetch_pc_stack dut (
        .clk        (clk),
        .reset      (reset),
        .hold       (hold),
        .s_inc      (s_inc),
        .s_pila     (s_pila),
        .push       (push),
        .pop        (pop),
        .jump_addr  (jump_addr),
        .pc         (pc),
        .sp         (sp),
        .stack_full (stack_full),
        .stack_empty(stack_empty),
        .stack_err  (stack_err),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc   = 0;
        m_q    = {};
        m_halt = 1'b0;
    endtask

    task automatic model_step(input bit h, input bit si, input bit spl,
                              input bit pu, input bit po, input int ja);
        int inc;
        int npc;
        bit err;
        if (h || m_halt) return;
        inc = (m_pc + 1) % PC_MOD;
        err = 1'b0;
        npc = si ? inc : ja;
        if (pu && po) begin
            npc = inc;
            err = 1'b1;
        end else if (po) begin
            if (m_q.size() == 0) begin
                npc = inc;
                err = 1'b1;
            end else begin
                int top;
                top = m_q.pop_back();
                if (spl) npc = top;
            end
        end else if (pu) begin
            if (m_q.size() == DEPTH) err = 1'b1;
            else m_q.push_back(inc);
        end
        if (err && GUARD) m_halt = 1'b1;
        else m_pc = npc;
    endtask

    task automatic cyc(input bit h, input bit si, input bit spl,
                       input bit pu, input bit po, input logic [PC_W-1:0] ja);
        hold = h; s_inc = si; s_pila = spl; push = pu; pop = po; jump_addr = ja;
        model_step(h, si, spl, pu, po, int'(ja));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        hold = 0; s_inc = 1; s_pila = 0; push = 0; pop = 0; jump_addr = '0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        hold = 0; s_inc = 1; s_pila = 0; push = 0; pop = 0; jump_addr = '0;
        reset = 1'b0;
        #2;
        n_tests++;
        if (pc !== 10'd0 || sp !== 4'd0) begin
            n_fail++; $display("FAIL reset_pc_sp: pc=%h sp=%0d required pc=000 sp=0", pc, sp);
        end
        n_tests++;
        if (stack_empty !== 1'b1 || stack_full !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: empty=%b full=%b required 1 0", stack_empty, stack_full);
        end
        n_tests++;
        if (stack_err !== 1'b0 || halted !== 1'b0) begin
            n_fail++; $display("FAIL reset_err: err=%b halted=%b required 0 0", stack_err, halted);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_sequential();
        do_reset();
        n_tests++;
        if (pc !== 10'd0) begin
            n_fail++; $display("FAIL seq_start: pc=%h required 000", pc);
        end
        for (int i = 1; i <= 5; i++) begin
            cyc(0, 1, 0, 0, 0, '0);
            n_tests++;
            if (pc !== PC_W'(i) || sp !== 4'd0 || stack_empty !== 1'b1) begin
                n_fail++; $display("FAIL seq_step%0d: pc=%h sp=%0d empty=%b required pc=%h sp=0 empty=1",
                                   i, pc, sp, stack_empty, i);
            end
        end
    endtask

    task automatic test_jump_wrap();
        do_reset();
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, '0);
        cyc(0, 0, 0, 0, 0, 10'h200);
        n_tests++;
        if (pc !== 10'h200) begin
            n_fail++; $display("FAIL jump_200: pc=%h required 200", pc);
        end
        cyc(0, 0, 0, 0, 0, 10'h3FF);
        cyc(0, 1, 0, 0, 0, 10'h155);
        n_tests++;
        if (pc !== 10'h000) begin
            n_fail++; $display("FAIL pc_wrap: pc=%h required 000", pc);
        end
    endtask

    task automatic test_call_return();
        do_reset();
        cyc(0, 0, 0, 0, 0, 10'h010);
        cyc(0, 0, 0, 1, 0, 10'h100);
        n_tests++;
        if (pc !== 10'h100 || sp !== 4'd1) begin
            n_fail++; $display("FAIL call_push: pc=%h sp=%0d required 100 1", pc, sp);
        end
        cyc(0, 1, 0, 0, 0, '0);
        cyc(0, 1, 0, 0, 0, '0);
        n_tests++;
        if (pc !== 10'h102) begin
            n_fail++; $display("FAIL call_body: pc=%h required 102", pc);
        end
        cyc(0, 1, 1, 0, 1, '0);
        n_tests++;
        if (pc !== 10'h011 || sp !== 4'd0 || stack_empty !== 1'b1) begin
            n_fail++; $display("FAIL call_return: pc=%h sp=%0d empty=%b required 011 0 1", pc, sp, stack_empty);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            cyc(0, 1, 0, 1, 0, '0);
            n_tests++;
            if (sp !== 4'(i + 1)) begin
                n_fail++; $display("FAIL ovf_fill%0d: sp=%0d required %0d", i, sp, i + 1);
            end
        end
        n_tests++;
        if (stack_full !== 1'b1) begin
            n_fail++; $display("FAIL ovf_full: full=%b required 1", stack_full);
        end
        cyc(0, 1, 0, 1, 0, '0);
        n_tests++;
        if (sp !== 4'd8 || stack_full !== 1'b1) begin
            n_fail++; $display("FAIL ovf_sp: sp=%0d full=%b required 8 1", sp, stack_full);
        end
        n_tests++;
        if (pc !== (GUARD ? 10'd8 : 10'd9) || halted !== GUARD || stack_err !== GUARD) begin
            n_fail++; $display("FAIL ovf_pc: pc=%h halted=%b err=%b required %h %b %b",
                               pc, halted, stack_err, GUARD ? 8 : 9, GUARD, GUARD);
        end
        cyc(0, 1, 0, 0, 0, '0);
        n_tests++;
        if (pc !== PC_W'(m_pc)) begin
            n_fail++; $display("FAIL ovf_after: pc=%h required %h", pc, m_pc);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        cyc(0, 0, 0, 0, 0, 10'h020);
        cyc(0, 1, 1, 0, 1, '0);
        n_tests++;
        if (pc !== (GUARD ? 10'h020 : 10'h021) || sp !== 4'd0 || halted !== GUARD) begin
            n_fail++; $display("FAIL underflow: pc=%h sp=%0d halted=%b required %h 0 %b",
                               pc, sp, halted, GUARD ? 10'h020 : 10'h021, GUARD);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        cyc(0, 0, 0, 0, 0, 10'h3FF);
        cyc(0, 0, 0, 1, 0, 10'h050);
        cyc(0, 1, 1, 0, 1, '0);
        n_tests++;
        if (pc !== 10'h000 || sp !== 4'd0) begin
            n_fail++; $display("FAIL b2b_wrap_ret: pc=%h sp=%0d required 000 0", pc, sp);
        end
        cyc(0, 1, 0, 1, 0, '0);
        cyc(0, 1, 0, 1, 1, '0);
        n_tests++;
        if (sp !== 4'd1 || pc !== PC_W'(m_pc) || stack_err !== GUARD) begin
            n_fail++; $display("FAIL push_pop_illegal: sp=%0d pc=%h err=%b required 1 %h %b",
                               sp, pc, stack_err, m_pc, GUARD);
        end
    endtask

    task automatic test_hold_reset();
        do_reset();
        cyc(0, 1, 0, 1, 0, '0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 0, 1, 0, '0);
            n_tests++;
            if (sp !== 4'd1 || pc !== 10'd1) begin
                n_fail++; $display("FAIL hold%0d: pc=%h sp=%0d required 001 1", i, pc, sp);
            end
        end
        hold = 0;
        #2;
        reset = 1'b0;
        #1;
        n_tests++;
        if (pc !== 10'd0 || sp !== 4'd0 || stack_empty !== 1'b1) begin
            n_fail++; $display("FAIL async_reset: pc=%h sp=%0d empty=%b required 000 0 1", pc, sp, stack_empty);
        end
        @(posedge clk);
        #1;
        push = 0;
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_random();
        for (int seg = 0; seg < 6; seg++) begin
            do_reset();
            for (int c = 0; c < 60; c++) begin
                cyc(($urandom % 5) == 0, ($urandom % 4) != 0, ($urandom % 2) == 0,
                    ($urandom % 4) == 0, ($urandom % 5) == 0, PC_W'($urandom));
                n_tests++;
                if (pc !== PC_W'(m_pc) || sp !== 4'(m_q.size())
                    || stack_full !== (m_q.size() == DEPTH) || stack_empty !== (m_q.size() == 0)
                    || halted !== m_halt || stack_err !== m_halt) begin
                    n_fail++;
                    $display("FAIL rand_s%0d_c%0d: pc=%h sp=%0d full=%b empty=%b halted=%b err=%b required pc=%h sp=%0d halted=%b",
                             seg, c, pc, sp, stack_full, stack_empty, halted, stack_err,
                             m_pc, m_q.size(), m_halt);
                end
            end
        end
    endtask

    initial begin
        hold = 0; s_inc = 1; s_pila = 0; push = 0; pop = 0; jump_addr = '0;
        reset = 1'b1;
        model_reset();
        #1;
        test_reset();
        test_sequential();
        test_jump_wrap();
        test_call_return();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_hold_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
